// File: rtl/vdg_pkg.sv
// ---------------------------------------------------------------------------
// vdg_pkg: shared constants, cell packing and fetch FSM encoding. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vdg_pkg;

  localparam int ATTR_AS  = 0;
  localparam int ATTR_EXT = 1;
  localparam int ATTR_INV = 2;
  localparam int ATTR_CSS = 3;

  localparam int CELL_W   = 12;
  localparam int CODE_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [CELL_W-1:0] pack_cell(
    input logic [7:0] code,
    input logic       css,
    input logic       inv,
    input logic       ext,
    input logic       as_bit
  );
    logic [CODE_LSB-1:0] attr;
    attr           = '0;
    attr[ATTR_AS]  = as_bit;
    attr[ATTR_EXT] = ext;
    attr[ATTR_INV] = inv;
    attr[ATTR_CSS] = css;
    return {code, attr};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vdg_line_buf.sv
// ---------------------------------------------------------------------------
// vdg_line_buf: two-bank simple dual-port line RAM, registered read. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vdg_line_buf
  import vdg_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = CELL_W,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // No reset on the array or read register so the tools can map it to block RAM.
  logic [WIDTH-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
    if (re) begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mc6847_row_fetch.sv
// ---------------------------------------------------------------------------
// mc6847_row_fetch: fetches one character row ahead into a ping-pong buffer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc6847_row_fetch
  import vdg_pkg::*;
#(
  parameter int MAX_COLS = 64,
  parameter int ADDR_W   = 13,
  parameter int MEM_LAT  = 2
) (
  input  logic              PIX_CLK,
  input  logic              RESET_N,
  input  logic              width_64,
  input  logic              row_start,
  input  logic [ADDR_W-1:0] row_base,
  input  logic              col_adv,
  output logic              RD,
  output logic [ADDR_W-1:0] DA,
  input  logic [7:0]        DD,
  input  logic              AS,
  input  logic              EXT,
  input  logic              INV,
  input  logic              CSS,
  output logic              cell_valid,
  output logic [7:0]        cell_code,
  output logic [3:0]        cell_attr,
  output logic              fetch_busy,
  output logic              overrun
);

  localparam int IDX_W = $clog2(MAX_COLS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] NCOLS_NARROW = CNT_W'(32);
  localparam logic [CNT_W-1:0] NCOLS_WIDE   = (MAX_COLS >= 64) ? CNT_W'(64) : CNT_W'(MAX_COLS);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [CNT_W-1:0]  ncols;
  logic [IDX_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  ret_cnt;
  logic [MEM_LAT-1:0] pipe_vld;
  logic [IDX_W-1:0]  pipe_idx [MEM_LAT];
  logic              bank_sel;
  logic [CNT_W-1:0]  rd_ptr;

  logic              issue_last;
  logic              ret_last;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              rd_hit;
  logic [CELL_W-1:0] rd_word;

  assign issue_last = ({1'b0, issue_cnt} == ncols - CNT_W'(1));
  assign wr_en      = pipe_vld[MEM_LAT-1];
  assign wr_idx     = pipe_idx[MEM_LAT-1];
  // DRAIN ends on the edge of the final write, so busy drops the next cycle.
  assign ret_last   = wr_en && (ret_cnt == ncols - CNT_W'(1));
  assign rd_hit     = col_adv && !row_start && (rd_ptr < ncols);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  state_next = ST_IDLE;
      ST_FETCH: if (issue_last) state_next = ST_DRAIN;
      ST_DRAIN: if (ret_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (row_start) begin
      state_next = ST_FETCH;
    end
  end

  assign fetch_busy = (state != ST_IDLE);

  always_ff @(posedge PIX_CLK) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      RD        <= 1'b0;
      DA        <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      ncols     <= NCOLS_NARROW;
      bank_sel  <= 1'b0;
      overrun   <= 1'b0;
      pipe_vld  <= '0;
    end else begin
      state <= state_next;
      RD    <= (state_next == ST_FETCH);

      if (row_start) begin
        DA        <= row_base;
        issue_cnt <= '0;
        ncols     <= width_64 ? NCOLS_WIDE : NCOLS_NARROW;
        bank_sel  <= ~bank_sel;
      end else if (state == ST_FETCH && !issue_last) begin
        DA        <= DA + ADDR_W'(1);
        issue_cnt <= issue_cnt + IDX_W'(1);
      end

      if (row_start) begin
        ret_cnt <= '0;
      end else if (wr_en) begin
        ret_cnt <= ret_cnt + CNT_W'(1);
      end

      if (row_start && state != ST_IDLE) begin
        overrun <= 1'b1;
      end

      for (int k = MEM_LAT - 1; k > 0; k--) begin
        pipe_vld[k] <= pipe_vld[k-1];
      end
      pipe_vld[0] <= RD;
      // Returns still in flight belong to the abandoned row and must never land.
      if (row_start) begin
        pipe_vld <= '0;
      end
    end
  end

  always_ff @(posedge PIX_CLK) begin
    for (int k = MEM_LAT - 1; k > 0; k--) begin
      pipe_idx[k] <= pipe_idx[k-1];
    end
    pipe_idx[0] <= issue_cnt;
  end

  always_ff @(posedge PIX_CLK) begin
    if (!RESET_N) begin
      rd_ptr     <= '0;
      cell_valid <= 1'b0;
    end else begin
      if (row_start) begin
        rd_ptr <= '0;
      end else if (rd_hit) begin
        rd_ptr <= rd_ptr + CNT_W'(1);
      end
      if (col_adv) begin
        cell_valid <= rd_hit;
      end
    end
  end

  vdg_line_buf #(
    .DEPTH (MAX_COLS),
    .WIDTH (CELL_W)
  ) u_line_buf (
    .clk     (PIX_CLK),
    .we      (wr_en),
    .wr_bank (~bank_sel),
    .wr_addr (wr_idx),
    .wr_data (pack_cell(DD, CSS, INV, EXT, AS)),
    .re      (rd_hit),
    .rd_bank (bank_sel),
    .rd_addr (rd_ptr[IDX_W-1:0]),
    .rd_data (rd_word)
  );

  // The RAM read register holds between col_adv pulses; masking gives zeros past the row end.
  assign cell_code = cell_valid ? rd_word[CELL_W-1:CODE_LSB] : 8'h00;
  assign cell_attr = cell_valid ? rd_word[CODE_LSB-1:0] : 4'h0;

endmodule

`default_nettype wire

// File: tb/tb_mc6847_row_fetch.sv
// ---------------------------------------------------------------------------
// tb_mc6847_row_fetch: directed/random bench with a row-level VRAM model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mc6847_row_fetch;

  localparam int MAX_COLS = 64;
  localparam int ADDR_W   = 13;
  localparam int MEM_LAT  = 2;
  localparam int MEM_SIZE = 1 << ADDR_W;

  logic              PIX_CLK = 1'b0;
  logic              RESET_N;
  logic              width_64;
  logic              row_start;
  logic [ADDR_W-1:0] row_base;
  logic              col_adv;
  logic              RD;
  logic [ADDR_W-1:0] DA;
  logic [7:0]        DD;
  logic              AS, EXT, INV, CSS;
  logic              cell_valid;
  logic [7:0]        cell_code;
  logic [3:0]        cell_attr;
  logic              fetch_busy;
  logic              overrun;

  always #5 PIX_CLK = ~PIX_CLK;

  mc6847_row_fetch #(
    .MAX_COLS (MAX_COLS),
    .ADDR_W   (ADDR_W),
    .MEM_LAT  (MEM_LAT)
  ) dut (
    .PIX_CLK    (PIX_CLK),
    .RESET_N    (RESET_N),
    .width_64   (width_64),
    .row_start  (row_start),
    .row_base   (row_base),
    .col_adv    (col_adv),
    .RD         (RD),
    .DA         (DA),
    .DD         (DD),
    .AS         (AS),
    .EXT        (EXT),
    .INV        (INV),
    .CSS        (CSS),
    .cell_valid (cell_valid),
    .cell_code  (cell_code),
    .cell_attr  (cell_attr),
    .fetch_busy (fetch_busy),
    .overrun    (overrun)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] mem_code [MEM_SIZE];
  logic [3:0] mem_attr [MEM_SIZE];
  int         mode;
  logic       tog;

  logic [ADDR_W:0]   hist [$];
  logic [ADDR_W-1:0] rd_log [$];
  int                busy_cnt;

  logic [11:0] exp_front [MAX_COLS];
  logic [11:0] exp_back  [MAX_COLS];
  int          front_known, back_known, cur_ncols, disp_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] addr_at(input logic [ADDR_W-1:0] base, input int i);
    return ADDR_W'((int'(base) + i) % MEM_SIZE);
  endfunction

  // Cell content as the VRAM model presents it: mode 0 = low address byte with AS,
  // mode 1 = random image, mode 2 = low address byte with INV toggling per returned byte.
  function automatic logic [11:0] exp_cell(input int md, input logic [ADDR_W-1:0] a, input int i);
    case (md)
      0:       return {a[7:0], 4'h1};
      1:       return {mem_code[a], mem_attr[a]};
      default: return {a[7:0], (i % 2 == 1) ? 4'h4 : 4'h0};
    endcase
  endfunction

  task automatic drive_vram(input logic [ADDR_W:0] req);
    logic [ADDR_W-1:0] a;
    a = req[ADDR_W-1:0];
    if (req[ADDR_W] === 1'b1) begin
      case (mode)
        0: begin DD = a[7:0]; {CSS, INV, EXT, AS} = 4'b0001; end
        1: begin DD = mem_code[a]; {CSS, INV, EXT, AS} = mem_attr[a]; end
        default: begin
          DD = a[7:0];
          {CSS, INV, EXT, AS} = {1'b0, tog, 2'b00};
          tog = ~tog;
        end
      endcase
    end else begin
      DD = 8'($urandom);
      {CSS, INV, EXT, AS} = 4'($urandom);
    end
  endtask

  task automatic step();
    @(posedge PIX_CLK);
    #1;
    if (RD === 1'b1) rd_log.push_back(DA);
    if (fetch_busy === 1'b1) busy_cnt++;
    hist.push_back({RD, DA});
    if (hist.size() > MEM_LAT) drive_vram(hist.pop_front());
    else drive_vram('0);
  endtask

  task automatic start_row(input logic [ADDR_W-1:0] base, input logic w64, input int md,
                           input logic with_col);
    int   n;
    logic was_busy;
    n        = w64 ? 64 : 32;
    was_busy = fetch_busy;
    for (int i = 0; i < MAX_COLS; i++) exp_front[i] = exp_back[i];
    front_known = was_busy ? 0 : back_known;
    for (int i = 0; i < n; i++) exp_back[i] = exp_cell(md, addr_at(base, i), i);
    back_known = n;
    cur_ncols  = n;
    disp_ptr   = 0;
    mode       = md;
    tog        = 1'b0;
    rd_log.delete();
    busy_cnt   = 0;
    row_base   = base;
    width_64   = w64;
    row_start  = 1'b1;
    col_adv    = with_col;
    step();
    row_start  = 1'b0;
    col_adv    = 1'b0;
  endtask

  task automatic col();
    col_adv = 1'b1;
    step();
    col_adv = 1'b0;
    if (disp_ptr < cur_ncols) begin
      chk($sformatf("valid[%0d]", disp_ptr), 32'(cell_valid), 32'd1);
      if (disp_ptr < front_known) begin
        chk($sformatf("code[%0d]", disp_ptr), 32'(cell_code), 32'(exp_front[disp_ptr][11:4]));
        chk($sformatf("attr[%0d]", disp_ptr), 32'(cell_attr), 32'(exp_front[disp_ptr][3:0]));
      end
      disp_ptr++;
    end else begin
      chk("past_end_valid", 32'(cell_valid), 32'd0);
      chk("past_end_code", 32'(cell_code), 32'd0);
      chk("past_end_attr", 32'(cell_attr), 32'd0);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (fetch_busy !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(fetch_busy), 32'd0);
  endtask

  task automatic check_fetch(input logic [ADDR_W-1:0] base, input int n, input string tag);
    chk({tag, "_rd_count"}, 32'(rd_log.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_da[%0d]", tag, i),
          (i < rd_log.size()) ? 32'(rd_log[i]) : 32'hFFFF_FFFF, 32'(addr_at(base, i)));
    end
  endtask

  logic [ADDR_W-1:0] rb;
  logic [11:0]       held;

  initial begin
    RESET_N = 1'b0; width_64 = 1'b0; row_start = 1'b0; row_base = '0; col_adv = 1'b0;
    DD = 8'h00; {CSS, INV, EXT, AS} = 4'h0;
    mode = 0; tog = 1'b0; busy_cnt = 0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      mem_code[i] = 8'($urandom);
      mem_attr[i] = 4'($urandom);
    end
    for (int i = 0; i < MAX_COLS; i++) begin exp_front[i] = '0; exp_back[i] = '0; end
    front_known = 0; back_known = 0; cur_ncols = 32; disp_ptr = 0;

    repeat (4) step();
    chk("rst_rd", 32'(RD), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_valid", 32'(cell_valid), 32'd0);
    chk("rst_code", 32'(cell_code), 32'd0);
    chk("rst_attr", 32'(cell_attr), 32'd0);
    chk("rst_da", 32'(DA), 32'd0);
    RESET_N = 1'b1;
    repeat (3) step();

    // 32-column row at 0x0100 with AS set on every byte
    start_row(13'h0100, 1'b0, 0, 1'b0);
    chk("a_first_rd", 32'(RD), 32'd1);
    wait_idle(200, "a_idle");
    check_fetch(13'h0100, 32, "a");
    chk("a_busy_len", 32'(busy_cnt), 32'(32 + MEM_LAT));
    repeat (5) step();

    // Random 32-column row while displaying the first one, plus one step past the end
    rb = ADDR_W'($urandom);
    start_row(rb, 1'b0, 1, 1'b0);
    repeat (33) col();
    wait_idle(200, "b_idle");
    check_fetch(rb, 32, "b");

    // 64-column row that wraps the address space, INV toggling per returned byte
    start_row(13'h1FE0, 1'b1, 2, 1'b0);
    col();
    held = exp_front[0];
    repeat (3) step();
    chk("hold_valid", 32'(cell_valid), 32'd1);
    chk("hold_code", 32'(cell_code), 32'(held[11:4]));
    repeat (31) col();
    wait_idle(200, "c_idle");
    check_fetch(13'h1FE0, 64, "c");
    chk("c_busy_len", 32'(busy_cnt), 32'(64 + MEM_LAT));

    // Display the wrapped row: codes follow the wrapped addresses, attr alternates 0/4
    rb = ADDR_W'($urandom);
    start_row(rb, 1'b1, 1, 1'b0);
    repeat (65) col();
    wait_idle(200, "d_idle");
    check_fetch(rb, 64, "d");

    // Overrun: second row_start 40 cycles into a 64-column fetch
    rb = ADDR_W'($urandom);
    start_row(rb, 1'b1, 1, 1'b0);
    repeat (39) step();
    chk("pre_overrun", 32'(overrun), 32'd0);
    rb = ADDR_W'($urandom);
    start_row(rb, 1'b1, 1, 1'b0);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("f_first_rd", 32'(RD), 32'd1);
    chk("f_first_da", 32'(DA), 32'(rb));
    wait_idle(200, "f_idle");
    check_fetch(rb, 64, "f");
    chk("f_busy_len", 32'(busy_cnt), 32'(64 + MEM_LAT));

    // Collision: col_adv together with row_start, then the restarted row is displayed
    col();
    rb = ADDR_W'($urandom);
    start_row(rb, 1'b1, 1, 1'b1);
    chk("collide_valid", 32'(cell_valid), 32'd0);
    repeat (65) col();
    chk("overrun_sticky", 32'(overrun), 32'd1);
    wait_idle(200, "g_idle");

    // Reset in the middle of a fetch
    rb = ADDR_W'($urandom);
    start_row(rb, 1'b1, 1, 1'b0);
    repeat (10) step();
    RESET_N = 1'b0;
    rd_log.delete();
    step();
    chk("midrst_rd", 32'(RD), 32'd0);
    chk("midrst_busy", 32'(fetch_busy), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    repeat (2) step();
    RESET_N = 1'b1;
    front_known = 0;
    back_known  = 0;
    repeat (20) step();
    chk("no_rd_after_rst", 32'(rd_log.size()), 32'd0);

    // Normal operation after reset
    rb = ADDR_W'($urandom);
    start_row(rb, 1'b0, 1, 1'b0);
    wait_idle(200, "i_idle");
    check_fetch(rb, 32, "i");
    rb = ADDR_W'($urandom);
    start_row(rb, 1'b0, 0, 1'b0);
    repeat (33) col();
    wait_idle(200, "j_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
